// File: rtl/dense_col_scheduler_pkg.sv
// Shared constants and state type for the dense-layer column scheduler.
package dense_col_scheduler_pkg;

  localparam int unsigned CHAR_NUM  = 200;
  localparam int unsigned COL_IDX_W = 8;
  localparam int unsigned INNER_LAT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/dense_col_scheduler_if.sv
// Control, fetch and write-strobe signals between the dense layer top and its column scheduler.
interface dense_col_scheduler_if #(
  parameter int unsigned COL_W = dense_col_scheduler_pkg::COL_IDX_W
);
  logic             start;
  logic             abort;
  logic             fetch_req;
  logic [COL_W-1:0] fetch_col;
  logic             fetch_ack;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic             busy;
  logic             done;
  logic             valid;

  modport master (
    input  start, abort, fetch_ack,
    output fetch_req, fetch_col, wr_en, wr_col, busy, done, valid
  );

  modport slave (
    output start, abort, fetch_ack,
    input  fetch_req, fetch_col, wr_en, wr_col, busy, done, valid
  );
endinterface

// File: rtl/dense_col_scheduler_lat_pipe.sv
// LAT-deep valid+index delay line with synchronous flush, for fixed-latency compute units.
module dense_col_scheduler_lat_pipe #(
  parameter int unsigned LAT = 4,
  parameter int unsigned W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0]        vld_q, vld_d;
  logic [LAT-1:0][W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = '0;
    dat_d = '0;
    if (!flush) begin
      vld_d[0] = in_valid;
      dat_d[0] = in_data;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/dense_col_scheduler.sv
// Sequences one dense-layer pass: fetches COL_NUM weight columns and strobes each result
// into the output buffer LAT cycles after its fetch is acknowledged.
module dense_col_scheduler
  import dense_col_scheduler_pkg::*;
#(
  parameter int unsigned COL_NUM = CHAR_NUM,
  parameter int unsigned COL_W   = COL_IDX_W,
  parameter int unsigned LAT     = INNER_LAT
) (
  input logic                   clk,
  input logic                   rst_n,
  dense_col_scheduler_if.master bus
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COL_NUM - 1);

  sched_state_e     state_q, state_d;
  logic [COL_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             valid_q, valid_d;
  logic             fetch_req;
  logic             ack_take;
  logic             pipe_valid;
  logic [COL_W-1:0] pipe_col;

  assign fetch_req = (state_q == ST_FETCH);
  // An ack coinciding with abort is dropped before it reaches the pipeline.
  assign ack_take  = fetch_req && bus.fetch_ack && !bus.abort;

  dense_col_scheduler_lat_pipe #(
    .LAT (LAT),
    .W   (COL_W)
  ) u_lat_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.abort),
    .in_valid  (ack_take),
    .in_data   (issue_cnt_q),
    .out_valid (pipe_valid),
    .out_data  (pipe_col)
  );

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    valid_d     = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d     = ST_FETCH;
          issue_cnt_d = '0;
          valid_d     = 1'b0;
        end
      end
      ST_FETCH: begin
        // Count holds at the last column instead of incrementing past it.
        if (ack_take) begin
          if (issue_cnt_q == LAST_COL) state_d = ST_DRAIN;
          else                         issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (pipe_valid && (pipe_col == LAST_COL)) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        issue_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort) begin
      valid_d     = 1'b0;
      issue_cnt_d = '0;
      if ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.fetch_req = fetch_req;
  assign bus.fetch_col = issue_cnt_q;
  assign bus.wr_en     = pipe_valid;
  assign bus.wr_col    = pipe_col;
  assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.valid     = valid_q;

endmodule

// File: tb/tb_dense_col_scheduler.sv
// Self-checking bench for dense_col_scheduler against a queue-based pass model.
module tb_dense_col_scheduler;

  localparam int unsigned COL_NUM = 200;
  localparam int unsigned COL_W   = 8;
  localparam int unsigned LAT     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dense_col_scheduler_if #(.COL_W(COL_W)) bus();

  dense_col_scheduler #(
    .COL_NUM (COL_NUM),
    .COL_W   (COL_W),
    .LAT     (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a pass is active from accepted start until its last write;
  // every accepted ack schedules a write LAT cycles later.
  typedef struct { int due; int col; } wr_t;
  wr_t m_wq[$];
  bit  m_active = 0;
  bit  m_done   = 0;
  bit  m_valid  = 0;
  int  m_issued = 0;
  int  m_cyc    = 0;

  int n_wr, n_done, done_at;

  function automatic logic [20:0] exp_vec();
    bit req, wr;
    int wc;
    req = m_active && (m_issued < int'(COL_NUM));
    wr  = (m_wq.size() > 0) && (m_wq[0].due == m_cyc);
    wc  = wr ? m_wq[0].col : 0;
    return {m_active, req, req ? 8'(m_issued) : 8'd0, wr, 8'(wc), m_done, m_valid};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {bus.busy, bus.fetch_req, (bus.fetch_req === 1'b1) ? bus.fetch_col : 8'd0,
            bus.wr_en, (bus.wr_en === 1'b1) ? bus.wr_col : 8'd0, bus.done, bus.valid};
  endfunction

  function automatic string fmt(input logic [20:0] v);
    return $sformatf("busy=%b req=%b col=%0d wr=%b wcol=%0d done=%b valid=%b",
                     v[20], v[19], v[18:11], v[10], v[9:2], v[1], v[0]);
  endfunction

  task automatic model_edge(input bit s, input bit a, input bit k);
    bit req, wr, last, was_done;
    req      = m_active && (m_issued < int'(COL_NUM));
    wr       = (m_wq.size() > 0) && (m_wq[0].due == m_cyc);
    last     = wr && (m_wq[0].col == int'(COL_NUM) - 1);
    was_done = m_done;
    m_done   = 0;
    if (wr) void'(m_wq.pop_front());
    if (a) begin
      m_active = 0;
      m_issued = 0;
      m_wq.delete();
      m_valid  = 0;
    end else if (m_active) begin
      if (req && k) begin
        m_wq.push_back('{m_cyc + int'(LAT), m_issued});
        m_issued++;
      end
      if (last) begin
        m_active = 0;
        m_done   = 1;
        m_valid  = 1;
      end
    end else if (!was_done && s) begin
      m_active = 1;
      m_issued = 0;
      m_valid  = 0;
    end
    m_cyc++;
  endtask

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_valid  = 0;
    m_issued = 0;
    m_wq.delete();
  endtask

  task automatic drive(input bit s, input bit a, input bit k);
    bus.start     = s;
    bus.abort     = a;
    bus.fetch_ack = k;
    #1;
  endtask

  task automatic tick(input bit s, input bit a, input bit k);
    if (bus.wr_en === 1'b1) n_wr++;
    if (bus.done === 1'b1) begin
      n_done++;
      done_at = m_cyc;
    end
    @(posedge clk);
    model_edge(s, a, k);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit k;
    drive(0, 0, 0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs_vec() !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_values got %s exp all zero", fmt(obs_vec()));
    end
    rst_n = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 20; i++) begin
      k = 1'($urandom_range(0, 1));
      drive(0, 0, k);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL idle_ack cyc=%0d got %s exp %s", m_cyc, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick(0, 0, k);
    end
    n_vec++;
    if (n_wr !== 0) begin
      n_bad++;
      $display("FAIL idle_ack_wr_count got %0d exp 0", n_wr);
    end
  endtask

  task automatic test_start_abort_idle();
    bit s, a, k;
    n_wr = 0;
    for (int i = 0; i < 12; i++) begin
      s = (i == 0);
      a = (i == 0);
      k = 1'($urandom_range(0, 1));
      drive(s, a, k);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL start_abort_idle cyc=%0d got %s exp %s", m_cyc, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick(s, a, k);
    end
    n_vec++;
    if (n_wr !== 0) begin
      n_bad++;
      $display("FAIL start_abort_idle_wr_count got %0d exp 0", n_wr);
    end
  endtask

  task automatic test_full_pass(input string name);
    bit s;
    int start_at;
    n_wr     = 0;
    n_done   = 0;
    done_at  = -1;
    start_at = m_cyc;
    for (int i = 0; i < int'(COL_NUM + LAT) + 12; i++) begin
      s = (i == 0);
      drive(s, 0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got %s exp %s", name, m_cyc, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick(s, 0, 1);
    end
    n_vec++;
    if ((n_wr !== int'(COL_NUM)) || (n_done !== 1)) begin
      n_bad++;
      $display("FAIL %s_counts got wr=%0d done=%0d exp wr=%0d done=1", name, n_wr, n_done, COL_NUM);
    end
    n_vec++;
    if ((done_at - start_at) !== int'(COL_NUM + LAT + 1)) begin
      n_bad++;
      $display("FAIL %s_done_cycle got %0d exp %0d", name, done_at - start_at, COL_NUM + LAT + 1);
    end
  endtask

  task automatic test_ack_every3();
    bit s, k;
    n_wr   = 0;
    n_done = 0;
    for (int i = 0; i < int'(3 * COL_NUM) + 20; i++) begin
      s = (i == 0);
      k = ((i % 3) == 1);
      drive(s, 0, k);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL ack_every3 cyc=%0d got %s exp %s", m_cyc, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick(s, 0, k);
    end
    n_vec++;
    if ((n_wr !== int'(COL_NUM)) || (n_done !== 1)) begin
      n_bad++;
      $display("FAIL ack_every3_counts got wr=%0d done=%0d exp wr=%0d done=1", n_wr, n_done, COL_NUM);
    end
  endtask

  task automatic test_random_ack_stray_start();
    bit s, k, finished;
    n_wr     = 0;
    n_done   = 0;
    finished = 0;
    for (int i = 0; i < 1500; i++) begin
      s = (i == 0) || ((m_active || m_done) && ($urandom_range(0, 7) == 0));
      k = 1'($urandom_range(0, 1));
      drive(s, 0, k);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_ack cyc=%0d got %s exp %s", m_cyc, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick(s, 0, k);
      if (!m_active && !m_done) begin
        finished = 1;
        break;
      end
    end
    n_vec++;
    if (!finished || (n_wr !== int'(COL_NUM)) || (n_done !== 1)) begin
      n_bad++;
      $display("FAIL random_ack_counts got finished=%0d wr=%0d done=%0d exp finished=1 wr=%0d done=1",
               finished, n_wr, n_done, COL_NUM);
    end
  endtask

  task automatic test_abort();
    bit s, a, seen50;
    int abort_i;
    seen50  = 0;
    abort_i = -1;
    for (int i = 0; i < 400; i++) begin
      s = (i == 0);
      a = seen50 && (abort_i < 0);
      drive(s, a, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL abort_pass cyc=%0d got %s exp %s", m_cyc, fmt(obs_vec()), fmt(exp_vec()));
      end
      if (!seen50 && (bus.wr_en === 1'b1) && (bus.wr_col == 8'd50)) seen50 = 1;
      tick(s, a, 1);
      if (a) begin
        abort_i = i;
        n_wr    = 0;
        n_done  = 0;
      end
      if ((abort_i >= 0) && (i >= abort_i + 30)) break;
    end
    n_vec++;
    if ((abort_i < 0) || (n_wr !== 0) || (n_done !== 0)) begin
      n_bad++;
      $display("FAIL abort_after_counts got aborted_at=%0d wr=%0d done=%0d exp wr=0 done=0",
               abort_i, n_wr, n_done);
    end
  endtask

  task automatic test_reset_drain();
    bit s, seen197;
    seen197 = 0;
    for (int i = 0; i < 400; i++) begin
      s = (i == 0);
      drive(s, 0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_drain_pass cyc=%0d got %s exp %s", m_cyc, fmt(obs_vec()), fmt(exp_vec()));
      end
      if ((bus.wr_en === 1'b1) && (bus.wr_col == 8'd197)) begin
        seen197 = 1;
        break;
      end
      tick(s, 0, 1);
    end
    n_vec++;
    if (!seen197) begin
      n_bad++;
      $display("FAIL reset_drain_reach got no wr_col=197 exp wr_col=197 within budget");
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs_vec() !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_drain_async got %s exp all zero", fmt(obs_vec()));
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_wr  = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_drain_after cyc=%0d got %s exp %s", m_cyc, fmt(obs_vec()), fmt(exp_vec()));
      end
      tick(0, 0, 1);
    end
    n_vec++;
    if (n_wr !== 0) begin
      n_bad++;
      $display("FAIL reset_drain_wr_count got %0d exp 0", n_wr);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.fetch_ack = 1'b0;
    test_reset();
    test_start_abort_idle();
    test_full_pass("full_pass");
    test_ack_every3();
    test_random_ack_stray_start();
    test_abort();
    test_full_pass("restart_pass");
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got still running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/dense_col_scheduler.md
Name: dense_col_scheduler

Overview:
Sequences one dense-layer pass over COL_NUM output columns (characters).
- Fetches one weight column per handshake from the column fetch unit (dense_block).
- Tracks each fetched column through the fixed-latency inner-product array (N parallel inner_24 instances).
- Issues a write strobe with the column index to the layer's output buffer when the result lands.
- Sits between the dense layer top and its fetch/compute units, replacing ad-hoc count/index logic.

Parameters:
COL_NUM, 200, output columns per pass (CHAR_NUM)
COL_W, 8, width of column index; 2**COL_W >= COL_NUM
LAT, 4, cycles from fetch_ack to inner-product result valid; LAT >= 1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse: begin a pass
abort  in  1  one-cycle pulse: cancel current pass
fetch_req  out  1  request weight column fetch_col
fetch_col  out  COL_W  column index requested
fetch_ack  in  1  weight column valid this cycle; consumes the request
wr_en  out  1  write inner-product results for wr_col into output buffer
wr_col  out  COL_W  column index for wr_en
busy  out  1  pass in progress
done  out  1  one-cycle pulse: last column written
valid  out  1  level: output buffer complete; held until next accepted start, abort or reset

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; pipeline shift register cleared.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start → FETCH next cycle; valid cleared same edge.
  - abort in IDLE: no effect.
- FETCH:
  - busy=1; fetch_req=1 while issue count < COL_NUM.
  - fetch_col = issue count.
  - fetch_ack with fetch_req=1 → issue count +1 at edge; req may remain high back-to-back (one column per cycle max).
  - On the ack consuming column COL_NUM-1 → DRAIN; fetch_req low from next cycle.
- Latency pipeline:
  - LAT-deep shift register of {valid, col}.
  - Ack in cycle k → wr_en=1, wr_col=col in cycle k+LAT, exactly one cycle.
  - wr_col is strictly increasing 0..COL_NUM-1 with no gaps or duplicates.
- DRAIN:
  - busy=1; fetch_req=0.
  - Cycle wr_en carries COL_NUM-1 → DONE next cycle.
- DONE (one cycle):
  - done=1; busy=0; valid=1 set at entry and held; → IDLE.
- Edge cases:
  - fetch_ack while fetch_req=0 (IDLE/DRAIN/DONE): ignored, never enters pipeline.
  - start while busy or in DONE: ignored.
  - start and abort in same cycle in IDLE: abort wins, start ignored.
  - abort in FETCH/DRAIN: → IDLE next edge; pipeline flushed; no further wr_en; no done; valid=0; counters 0.
  - abort and fetch_ack same cycle: ack discarded.
  - Async reset mid-pass: immediate return to reset values; no wr_en after reset release until a new start.
- Counters: COL_W bits; terminal compare against COL_NUM-1, never wraps.

Decomposition:
- Shared package/include (consts.vh): CHAR_NUM (COL_NUM default), column index width, INNER_LAT (=4, inner_24 latency).
- State encoding localparams live in the module.
- One natural sub-module: lat_pipe, parameterized LAT-deep valid+index delay line with synchronous flush, reusable for other fixed-latency units.

Test Plan:
- Reset → all outputs 0, state IDLE. fetch_ack pulses while idle → no wr_en ever.
- start at cycle 0, fetch_ack tied 1 → fetch_req cycles 1..200, wr_en cycles 5..204 with wr_col 0..199, done at 205, busy low at 205, valid high from 205 and held.
- fetch_ack every 3rd cycle → wr_col increments by 1 every 3 cycles, each exactly LAT=4 after its ack; total 200 wr_en pulses, single done.
- abort the cycle after wr_col=50 → busy 0 next cycle, no further wr_en, no done, valid 0. A new start restarts at fetch_col 0 and completes normally.
- start pulsed during FETCH, and start+abort together in IDLE → both ignored; issue and write sequence unchanged.
- rst_n low during DRAIN (wr_col=197 just written) → outputs 0 immediately; no wr_en for cols 198/199 after release; valid 0.
